// File: rtl/lcd_frame_sched_pkg.sv
// Shared types and defaults for the LCD frame scheduler: FSM encoding,
// default geometry and the one-hot priority helper.
package lcd_frame_sched_pkg;

  localparam int NUM_IMG_D = 3;
  localparam int ADDR_W_D  = 17;
  localparam int PIX_W_D   = 16;
  localparam int TIMEOUT_D = 2000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Isolates the lowest set bit, so bit 0 wins when several images are requested.
  function automatic logic [31:0] lowest_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/lcd_frame_sched_if.sv
// Frame/pixel handshake between the scheduler (slave) and the display engine (master).
interface lcd_frame_sched_if
  import lcd_frame_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int PIX_W  = PIX_W_D
) ();

  logic              frame_start;
  logic              frame_done;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_vld;

  modport master (
    output frame_done, pix_req, pix_addr,
    input  frame_start, pix_data, pix_vld
  );

  modport slave (
    input  frame_done, pix_req, pix_addr,
    output frame_start, pix_data, pix_vld
  );

endinterface

// File: rtl/lcd_pix_mux.sv
// Pixel return path: selects the active ROM slice, registers it, and delays
// the fetch strobe by two cycles to line up with the one-cycle ROM latency.
module lcd_pix_mux
  import lcd_frame_sched_pkg::*;
#(
  parameter int NUM_IMG = NUM_IMG_D,
  parameter int PIX_W   = PIX_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [NUM_IMG-1:0]       sel,
  input  logic [NUM_IMG*PIX_W-1:0] rom_dout,
  output logic [PIX_W-1:0]         pix_data,
  output logic                     pix_vld
);

  logic [PIX_W-1:0] data_s;
  logic             vld_d1_r;

  // One-hot AND-OR select; an all-zero select yields a zero pixel.
  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_IMG; i++) begin
      if (sel[i]) begin
        data_s = data_s | rom_dout[i*PIX_W +: PIX_W];
      end else begin
        data_s = data_s;
      end
    end
  end

  // Output register and strobe delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d1_r <= 1'b0;
      pix_vld  <= 1'b0;
      pix_data <= '0;
    end else begin
      vld_d1_r <= req;
      pix_vld  <= vld_d1_r;
      pix_data <= data_s;
    end
  end

endmodule

// File: rtl/lcd_frame_sched.sv
// Frame-level scheduler: captures one-hot image requests, never switches image
// mid-frame, guards each frame with a watchdog and drives the selected ROM.
module lcd_frame_sched
  import lcd_frame_sched_pkg::*;
#(
  parameter int NUM_IMG = NUM_IMG_D,
  parameter int ADDR_W  = ADDR_W_D,
  parameter int PIX_W   = PIX_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic                     clk,
  input  logic                     rst,
  lcd_frame_sched_if.slave         disp,
  input  logic [NUM_IMG-1:0]       img_req,
  output logic [NUM_IMG-1:0]       rom_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [NUM_IMG*PIX_W-1:0] rom_dout,
  output logic [NUM_IMG-1:0]       cur_img,
  output logic                     busy,
  output logic                     err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_r, state_s;
  logic [NUM_IMG-1:0] last_req_r;
  logic [NUM_IMG-1:0] pend_r, pend_s;
  logic               pend_vld_r, pend_vld_s;
  logic               new_req_s, pend_any_s, load_s;
  logic [NUM_IMG-1:0] cur_img_s;
  logic [WD_W-1:0]    wd_r, wd_s;
  logic               err_s;
  logic               pix_go_s;

  assign rom_addr = disp.pix_addr;
  assign pix_go_s = disp.pix_req && (state_r == STREAM);

  // A request seen this cycle is already visible to the FSM, so a change that
  // coincides with frame_done (or arrives in IDLE) is used by the next frame.
  always_comb begin
    new_req_s = (img_req != last_req_r) && (img_req != '0);
    if (new_req_s) begin
      pend_s     = NUM_IMG'(lowest_bit(32'(img_req)));
      pend_any_s = 1'b1;
    end else begin
      pend_s     = pend_r;
      pend_any_s = pend_vld_r;
    end
  end

  // Next-state, watchdog and sticky error logic.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    cur_img_s = cur_img;
    wd_s      = wd_r;
    err_s     = err;
    case (state_r)
      IDLE: begin
        if (pend_any_s) begin
          state_s = START;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = STREAM;
        wd_s    = '0;
      end
      STREAM: begin
        wd_s = wd_r + WD_W'(1);
        if (disp.frame_done) begin
          if (pend_any_s) begin
            state_s = START;
            load_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
          state_s   = IDLE;
          err_s     = 1'b1;
          cur_img_s = '0;
        end else begin
          state_s = STREAM;
        end
      end
      default: begin
        state_s   = IDLE;
        cur_img_s = '0;
      end
    endcase
    if (load_s) begin
      cur_img_s = pend_s;
    end else begin
      cur_img_s = cur_img_s;
    end
  end

  // State, request capture and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= IDLE;
      last_req_r       <= '0;
      pend_r           <= '0;
      pend_vld_r       <= 1'b0;
      wd_r             <= '0;
      cur_img          <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
      rom_en           <= '0;
      disp.frame_start <= 1'b0;
    end else begin
      state_r          <= state_s;
      last_req_r       <= img_req;
      pend_r           <= pend_s;
      pend_vld_r       <= pend_any_s && !load_s;
      wd_r             <= wd_s;
      cur_img          <= cur_img_s;
      err              <= err_s;
      busy             <= (state_s != IDLE);
      rom_en           <= (state_s != IDLE) ? cur_img_s : '0;
      disp.frame_start <= (state_s == START);
    end
  end

  lcd_pix_mux #(
    .NUM_IMG (NUM_IMG),
    .PIX_W   (PIX_W)
  ) u_pix_mux (
    .clk      (clk),
    .rst      (rst),
    .req      (pix_go_s),
    .sel      (cur_img),
    .rom_dout (rom_dout),
    .pix_data (disp.pix_data),
    .pix_vld  (disp.pix_vld)
  );

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Directed bench for lcd_frame_sched with a behavioural ROM and a pixel scoreboard.
module tb_lcd_frame_sched;
  import lcd_frame_sched_pkg::*;

  localparam int NI = 3;
  localparam int AW = 17;
  localparam int PW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    img_req;
  logic [NI-1:0]    rom_en;
  logic [AW-1:0]    rom_addr;
  logic [NI*PW-1:0] rom_dout = '0;
  logic [NI-1:0]    cur_img;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  lcd_frame_sched_if #(.ADDR_W(AW), .PIX_W(PW)) disp ();

  lcd_frame_sched #(
    .NUM_IMG (NI),
    .ADDR_W  (AW),
    .PIX_W   (PW),
    .TIMEOUT (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .disp     (disp),
    .img_req  (img_req),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .cur_img  (cur_img),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rom_val(input int img, input logic [AW-1:0] a);
    logic [31:0] t;
    t = (img + 1) * 32'h0001_1357 + 32'(a);
    return t[15:0] ^ t[31:16];
  endfunction

  // Behavioural ROMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rom_en[i]) rom_dout[i*PW +: PW] <= rom_val(i, rom_addr);
    end
  end

  // Scoreboard: every valid pixel must match the oldest outstanding request.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (disp.pix_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL pix_unexpected: pix_vld=1 data=%0h, expected no pixel", disp.pix_data);
      end else begin
        e = exp_q.pop_front();
        assert (disp.pix_data === e) else begin
          errors++;
          $error("FAIL pix_data: got %0h expected %0h", disp.pix_data, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic done_pulse();
    disp.frame_done = 1'b1;
    tick();
    disp.frame_done = 1'b0;
  endtask

  task automatic pix_burst(input int img, input logic [AW-1:0] a0, input int n);
    for (int k = 0; k < n; k++) begin
      disp.pix_req  = 1'b1;
      disp.pix_addr = a0 + AW'(k * 37);
      exp_q.push_back(rom_val(img, disp.pix_addr));
      if (k == 0) chk("rom_addr", 32'(rom_addr), 32'(disp.pix_addr));
      tick();
    end
    disp.pix_req = 1'b0;
    repeat (3) tick();
    chk("queue_drain", exp_q.size(), 0);
  endtask

  initial begin
    rst             = 1'b1;
    img_req         = '0;
    disp.frame_done = 1'b0;
    disp.pix_req    = 1'b0;
    disp.pix_addr   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_fs", 32'(disp.frame_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rom_en", 32'(rom_en), 0);
    chk("rst_err", 32'(err), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Basic frame on image 0
    img_req = 3'b001;
    tick();
    chk("t2_fs", 32'(disp.frame_start), 1);
    chk("t2_cur", 32'(cur_img), 32'h1);
    chk("t2_rom_en", 32'(rom_en), 32'h1);
    chk("t2_busy", 32'(busy), 1);
    tick();
    chk("t2_fs_pulse", 32'(disp.frame_start), 0);
    disp.pix_req  = 1'b1;
    disp.pix_addr = 17'd5;
    exp_q.push_back(rom_val(0, 17'd5));
    tick();
    disp.pix_req = 1'b0;
    chk("t2_vld_lat1", 32'(disp.pix_vld), 0);
    tick();
    chk("t2_vld_lat2", 32'(disp.pix_vld), 1);
    tick();
    pix_burst(0, 17'd100, 4);
    pix_burst(0, 17'h1FFFF, 1);

    // Request change mid-frame is deferred
    img_req = 3'b010;
    tick();
    chk("t3_cur_hold", 32'(cur_img), 32'h1);
    chk("t3_fs_none", 32'(disp.frame_start), 0);
    tick();
    chk("t3_rom_en_hold", 32'(rom_en), 32'h1);
    done_pulse();
    chk("t3_fs", 32'(disp.frame_start), 1);
    chk("t3_cur", 32'(cur_img), 32'h2);
    chk("t3_rom_en", 32'(rom_en), 32'h2);
    tick();
    chk("t3_fs_pulse", 32'(disp.frame_start), 0);
    pix_burst(1, 17'd7, 3);

    // Overwrite and priority
    img_req = 3'b000;
    tick();
    img_req = 3'b010;
    tick();
    img_req = 3'b100;
    tick();
    chk("t4_cur_hold", 32'(cur_img), 32'h2);
    done_pulse();
    chk("t4_fs_over", 32'(disp.frame_start), 1);
    chk("t4_cur_over", 32'(cur_img), 32'h4);
    tick();
    pix_burst(2, 17'd50, 2);
    img_req = 3'b011;
    tick();
    done_pulse();
    chk("t4_cur_prio", 32'(cur_img), 32'h1);
    tick();
    img_req = 3'b000;
    tick();
    done_pulse();
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_idle_fs", 32'(disp.frame_start), 0);
    chk("t4_idle_rom_en", 32'(rom_en), 0);
    disp.pix_req  = 1'b1;
    disp.pix_addr = 17'd9;
    tick();
    disp.pix_req = 1'b0;
    repeat (3) tick();
    chk("t4_no_frame", 32'(busy), 0);

    // frame_done coincident with a new request
    img_req = 3'b001;
    tick();
    chk("t5_fs0", 32'(disp.frame_start), 1);
    tick();
    tick();
    disp.frame_done = 1'b1;
    img_req         = 3'b100;
    tick();
    disp.frame_done = 1'b0;
    chk("t5_fs", 32'(disp.frame_start), 1);
    chk("t5_cur", 32'(cur_img), 32'h4);
    tick();

    // Watchdog: exactly 64 STREAM cycles without frame_done
    repeat (63) tick();
    chk("t6_busy63", 32'(busy), 1);
    chk("t6_err63", 32'(err), 0);
    tick();
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err), 1);
    chk("t6_cur", 32'(cur_img), 0);
    chk("t6_rom_en", 32'(rom_en), 0);
    img_req = 3'b010;
    tick();
    chk("t6_restart_fs", 32'(disp.frame_start), 1);
    chk("t6_restart_cur", 32'(cur_img), 32'h2);
    chk("t6_err_sticky", 32'(err), 1);
    tick();
    pix_burst(1, 17'd3, 2);
    done_pulse();
    chk("t6_err_end", 32'(err), 1);

    // Reset mid-frame
    img_req = 3'b001;
    tick();
    chk("t1_fs", 32'(disp.frame_start), 1);
    tick();
    tick();
    rst           = 1'b1;
    img_req       = 3'b000;
    disp.pix_req  = 1'b1;
    disp.pix_addr = 17'd11;
    tick();
    chk("t1_fs0", 32'(disp.frame_start), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_rom_en", 32'(rom_en), 0);
    chk("t1_vld", 32'(disp.pix_vld), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_cur", 32'(cur_img), 0);
    rst          = 1'b0;
    disp.pix_req = 1'b0;
    tick();
    chk("t1_vld_after", 32'(disp.pix_vld), 0);
    tick();
    chk("t1_idle", 32'(busy), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
